// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// command record sizing.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_ROL = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Command record is {op, chain, a, b}.
    function automatic int cmd_width(input int n, input int m);
        return (m - 1) + 1 + 2 * n;
    endfunction

    // Reserved opcodes return operand a from the unit and are flagged via rsp_err.
    function automatic logic is_reserved(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus between the sequencer and its surroundings: command port, arithmetic
// unit port and response port.
interface alu_cmd_sequencer_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [M-2:0]   cmd_op;
    logic           cmd_chain;
    logic [N-1:0]   cmd_a;
    logic [N-1:0]   cmd_b;

    logic [M-2:0]   ariu_instr;
    logic [N-1:0]   ariu_a;
    logic [N-1:0]   ariu_b;
    logic [N-1:0]   ariu_result;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [N-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;

    // master: control logic plus arithmetic unit; slave: the sequencer.
    modport master (
        output cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready, ariu_result,
        input  cmd_ready, ariu_instr, ariu_a, ariu_b, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chain, cmd_a, cmd_b, rsp_ready, ariu_result,
        output cmd_ready, ariu_instr, ariu_a, ariu_b, rsp_valid, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with head exposed from storage, full/empty flags
// and same-cycle push/pop.
module alu_cmd_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define validity, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the registered arithmetic unit: buffers commands, issues one
// at a time, captures results and returns them with an optional accumulator chain.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus
);

    localparam int CW = cmd_width(N, M);

    logic [CW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    logic [M-2:0]  head_op;
    logic          head_chain;
    logic [N-1:0]  head_a;
    logic [N-1:0]  head_b;

    state_t        state;
    logic [N-1:0]  acc;
    logic [M-2:0]  instr_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          rsp_valid_q;
    logic [N-1:0]  rsp_data_q;
    logic          rsp_err_q;

    assign {head_op, head_chain, head_a, head_b} = head;

    // The unit samples its inputs at the edge that ends ISSUE, so pop there.
    assign fifo_pop = (state == ISSUE);

    alu_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .wdata ({bus.cmd_op, bus.cmd_chain, bus.cmd_a, bus.cmd_b}),
        .pop   (fifo_pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.cmd_ready  = !fifo_full;
    assign bus.busy       = !fifo_empty || (state != IDLE);
    assign bus.ariu_instr = instr_q;
    assign bus.ariu_a     = a_q;
    assign bus.ariu_b     = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            instr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        instr_q <= head_op;
                        a_q     <= head_chain ? acc : head_a;
                        b_q     <= head_b;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // ariu_result is only trusted here; the unit has no reset.
                    rsp_data_q  <= bus.ariu_result;
                    acc         <= bus.ariu_result;
                    rsp_err_q   <= is_reserved(3'(instr_q));
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            instr_q <= head_op;
                            a_q     <= head_chain ? acc : head_a;
                            b_q     <= head_b;
                            state   <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the arithmetic-unit instruction interface.
- Accepts (opcode, a, b) commands over a valid/ready port and buffers them in a small FIFO.
- Issues commands one at a time to the registered arithmetic unit, captures each result after its one-clock latency and returns it over a valid/ready response port.
- Holds an accumulator so commands can chain on the previous result; sits between the control logic and the arithmetic unit.

Parameters:
N, 4, operand/result width
M, 4, instruction field width is M-1 (3 bits at default)
DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command FIFO not full
cmd_op  input  M-1  opcode
cmd_chain  input  1  1 = replace cmd_a with accumulator at issue
cmd_a  input  N  operand a
cmd_b  input  N  operand b
ariu_instr  output  M-1  instruction to arithmetic unit
ariu_a  output  N  operand a to arithmetic unit
ariu_b  output  N  operand b to arithmetic unit
ariu_result  input  N  registered result from arithmetic unit
rsp_valid  output  1  response held
rsp_ready  input  1  consumer accepts response
rsp_data  output  N  captured result
rsp_err  output  1  opcode was reserved (010 MUL, 011 DIV)
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except cmd_ready = 1. This means ariu_* = 0, rsp_valid/rsp_data/rsp_err = 0, busy = 0. FIFO is emptied, accumulator = 0, FSM = IDLE.
- Reset mid-operation: in-flight and buffered commands are discarded and no response is produced.
- Opcodes: 000 ADD, 001 SUB, 010 MUL (reserved), 011 DIV (reserved), 100 SHL, 101 SHR, 110 ROL, 111 ROR.
- Command push: occurs when cmd_valid & cmd_ready. cmd_ready = !full, with no same-cycle pass-through at full even if a pop occurs. Push and pop in the same cycle are legal when not full.
- FSM states and transitions:
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE: drive ariu_instr/ariu_a/ariu_b from the FIFO head. ariu_a = accumulator if chain = 1, else a. Pop the head at the clock edge ending this cycle; the arithmetic unit samples its inputs at that same edge. -> WAIT.
  - WAIT: hold ariu_* unchanged. ariu_result is now valid; at the edge ending WAIT, load rsp_data = ariu_result and accumulator = ariu_result. rsp_err = (op == 010 | op == 011). rsp_valid <= 1. -> RESP.
  - RESP: hold rsp_* stable until rsp_ready. On rsp_valid & rsp_ready: rsp_valid <= 0, then go to ISSUE if the FIFO is non-empty, else IDLE.
- ariu_* hold their last values in IDLE and RESP. ariu_result is never sampled outside WAIT, because the arithmetic unit has no reset.
- Latency: command pushed at edge 0 into an empty, idle block gives rsp_valid high after edge 3. Back-to-back throughput is one result per 3 cycles with rsp_ready held at 1.
- Arithmetic is performed by the arithmetic unit, modulo 2^N; the sequencer does no arithmetic. Reserved ops return the unit's default result (a) flagged by rsp_err; the accumulator is still updated.
- Chain after reset uses accumulator = 0.
- Capacity: DEPTH buffered commands plus one in flight (ISSUE/WAIT/RESP).

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD through OP_ROR);
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP);
  - command record width (M-1 + 1 + 2N).
- Sub-module alu_cmd_fifo: synchronous FIFO with registered head, full/empty flags, same-cycle push/pop, async active-high reset.

Test Plan:
- ADD a=9 b=8 -> rsp_data=0001, rsp_err=0, rsp_valid rises exactly 3 clocks after accept.
- SUB a=3 b=5 -> 1110; ROL a=1001 -> 0011; ROR a=1001 -> 1100; SHR a=1001 -> 0100.
- Chain: ADD 3+4 -> 0111, then SUB chain=1 a=x b=2 -> ariu_a observed 0111 in ISSUE, rsp_data=0101.
- Backpressure: rsp_ready=0 while pushing 6 commands -> 5 accepted (1 in flight + DEPTH), cmd_ready low; then rsp_ready=1 -> 5 responses in push order, unchanged while stalled.
- Reserved op 010 a=0110 b=0011 -> rsp_err=1, rsp_data=0110; next ADD -> rsp_err=0.
- Assert rst during WAIT with 2 queued -> all outputs at reset values asynchronously, no response after deassert, busy=0, accumulator=0 (chained ADD b=1 -> 0001).
